// File: rtl/pipe_stage_chain_if.sv
// Producer/consumer bundle around a pipe_stage_chain: the handshake and payload going in,
// the output slot and occupancy coming out.
interface pipe_stage_chain_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 2
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              stall;
    logic [DEPTH-1:0]  flush_mask;
    logic              valid_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic [DATA_W-1:0] data_in;
    logic              in_ready;
    logic              valid_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [DATA_W-1:0] data_out;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output stall, flush_mask, valid_in, ctrl_in, data_in,
        input  in_ready, valid_out, ctrl_out, data_out, occupancy
    );

    modport slave (
        input  stall, flush_mask, valid_in, ctrl_in, data_in,
        output in_ready, valid_out, ctrl_out, data_out, occupancy
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// Generic DEPTH-slot inter-stage pipeline register with per-slot valid, stall, per-slot flush,
// optional bubble collapsing (COLLAPSE=1) and a registered occupancy count.
module pipe_stage_chain #(
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 8,
    parameter int DEPTH    = 2,
    parameter int COLLAPSE = 0
) (
    input  logic              clk,
    input  logic              reset,
    pipe_stage_chain_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  v;
    logic [CTRL_W-1:0] c [DEPTH];
    logic [DATA_W-1:0] d [DEPTH];
    logic [OCC_W-1:0]  occ;

    logic [DEPTH-1:0]  load;
    logic [DEPTH-1:0]  pv;
    logic [CTRL_W-1:0] pc [DEPTH];
    logic [DATA_W-1:0] pd [DEPTH];
    logic [DEPTH-1:0]  v_next;
    logic [CTRL_W-1:0] c_next [DEPTH];
    logic [DATA_W-1:0] d_next [DEPTH];
    logic [OCC_W-1:0]  occ_next;

    // With collapsing, a slot may advance whenever everything downstream of it can make room.
    always_comb begin : load_enables
        logic chain;
        chain = !bus.stall;
        load  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            chain = chain | !v[k];
            load[k] = (COLLAPSE != 0) ? chain : !bus.stall;
        end
    end

    always_comb begin : predecessors
        pv    = '0;
        pv[0] = bus.valid_in;
        pc[0] = bus.ctrl_in;
        pd[0] = bus.data_in;
        for (int k = 1; k < DEPTH; k++) begin
            pv[k] = v[k-1] & ~bus.flush_mask[k-1];
            pc[k] = c[k-1];
            pd[k] = d[k-1];
        end
    end

    // A killed item either arrives downstream as a bubble or turns its own slot into one.
    always_comb begin : next_state
        logic nv;
        v_next   = '0;
        occ_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (load[k]) begin
                nv        = pv[k];
                c_next[k] = nv ? pc[k] : '0;
                d_next[k] = pd[k];
            end else begin
                nv        = v[k] & ~bus.flush_mask[k];
                c_next[k] = nv ? c[k] : '0;
                d_next[k] = d[k];
            end
            v_next[k] = nv;
            occ_next  = occ_next + OCC_W'(nv);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v   <= '0;
            occ <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                c[k] <= '0;
                d[k] <= '0;
            end
        end else begin
            v   <= v_next;
            occ <= occ_next;
            for (int k = 0; k < DEPTH; k++) begin
                c[k] <= c_next[k];
                d[k] <= d_next[k];
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.valid_out = v[DEPTH-1];
    assign bus.ctrl_out  = c[DEPTH-1];
    assign bus.data_out  = d[DEPTH-1];
    assign bus.occupancy = occ;
endmodule
